// File: rtl/hadamard_pam_transmitter.sv
// hadamard_pam_transmitter
// Spreads (HADAMARD-1) PAM symbols onto rows 1..HADAMARD-1 of a unipolar
// Sylvester Hadamard matrix, sums them into HADAMARD chips, prefixes the
// preamble and presents the frame both in parallel and bit-serially.
//
// Build option: define HADAMARD_TX_GRAY_MAP_EN to Gray-decode each symbol
// before spreading. Frame layout and timing do not change.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a payload word (input_ready = 1)
// S_ENCODE | one chip per cycle, chip index 0..HADAMARD-1
// S_SERIAL | frame shifted out MSB first, bit index 0..N-1
module hadamard_pam_transmitter #(
    parameter int          HADAMARD      = 16,
    parameter int          PAM_LEVEL_LOG = 2,
    parameter int          BIT_NUM       = 6,
    parameter logic [3:0]  PREAMBLE      = 4'b1010,
    parameter int          N             = BIT_NUM * HADAMARD + 4,
    parameter int          M             = (HADAMARD - 1) * PAM_LEVEL_LOG
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [M-1:0] input_data,
    input  logic         input_valid,
    output logic         input_ready,
    output logic [N-1:0] output_data,
    output logic         output_valid,
    output logic         serial_out,
    output logic         serial_valid
);

    localparam int CHIP_W = $clog2(HADAMARD);
    localparam int CNT_W  = $clog2(N);
    localparam int ACC_W  = BIT_NUM * (HADAMARD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_SERIAL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_input_ready;
    logic [M-1:0]          r_payload;
    logic [CHIP_W-1:0]     r_chip_idx;
    logic [ACC_W-1:0]      r_chip_acc;
    logic [BIT_NUM-1:0]    w_chip;
    logic [N-1:0]          w_frame;
    logic [N-1:0]          r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [N-1:0]          r_output_data;
    logic                  r_output_valid;
    logic                  r_serial_out;
    logic                  r_serial_valid;

    // Map a raw symbol field to its PAM level.
    function automatic logic [PAM_LEVEL_LOG-1:0] f_level(
        input logic [PAM_LEVEL_LOG-1:0] sym
    );
        logic [PAM_LEVEL_LOG-1:0] lvl;
`ifdef HADAMARD_TX_GRAY_MAP_EN
        lvl = '0;
        lvl[PAM_LEVEL_LOG-1] = sym[PAM_LEVEL_LOG-1];
        for (int i = PAM_LEVEL_LOG - 2; i >= 0; i--) begin
            lvl[i] = lvl[i+1] ^ sym[i];
        end
`else
        lvl = sym;
`endif
        return lvl;
    endfunction

    // Chip for the current index: sum of levels whose row has an even
    // popcount(k AND n). Worst case (HADAMARD-1)*(2^P-1) fits BIT_NUM bits.
    always_comb begin
        w_chip = '0;
        for (int k = 1; k < HADAMARD; k++) begin
            if ((^(CHIP_W'(k) & r_chip_idx)) == 1'b0) begin
                w_chip = w_chip + BIT_NUM'(f_level(
                    r_payload[M-1-(k-1)*PAM_LEVEL_LOG -: PAM_LEVEL_LOG]));
            end
        end
    end

    // Complete frame as it will look once the last chip is appended.
    always_comb begin
        w_frame = {PREAMBLE, r_chip_acc, w_chip};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake.
    always_comb begin
        w_state_next  = r_state;
        w_input_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_input_ready = 1'b1;
                if (input_valid) begin
                    w_state_next = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (r_chip_idx == CHIP_W'(HADAMARD - 1)) begin
                    w_state_next = S_SERIAL;
                end
            end
            S_SERIAL: begin
                if (r_bit_cnt == CNT_W'(N - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: payload capture, chip accumulation, frame publish, shifting.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_payload      <= '0;
            r_chip_idx     <= '0;
            r_chip_acc     <= '0;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_output_data  <= '0;
            r_output_valid <= 1'b0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
        end else begin
            r_output_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    if (input_valid) begin
                        r_payload  <= input_data;
                        r_chip_idx <= '0;
                    end
                end
                S_ENCODE: begin
                    r_chip_acc <= {r_chip_acc[ACC_W-BIT_NUM-1:0], w_chip};
                    if (r_chip_idx == CHIP_W'(HADAMARD - 1)) begin
                        r_output_data  <= w_frame;
                        r_output_valid <= 1'b1;
                        r_shift        <= w_frame;
                        r_bit_cnt      <= '0;
                        r_chip_idx     <= '0;
                    end else begin
                        r_chip_idx <= r_chip_idx + 1'b1;
                    end
                end
                S_SERIAL: begin
                    r_serial_out   <= r_shift[N-1];
                    r_serial_valid <= 1'b1;
                    r_shift        <= {r_shift[N-2:0], 1'b0};
                    if (r_bit_cnt != CNT_W'(N - 1)) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                end
            endcase
        end
    end

    assign input_ready  = w_input_ready;
    assign output_data  = r_output_data;
    assign output_valid = r_output_valid;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;

endmodule

// File: tb/tb_hadamard_pam_transmitter.sv
// Testbench for hadamard_pam_transmitter: behavioural frame model plus
// per-cycle output comparison, directed cases and randomized traffic.
module tb_hadamard_pam_transmitter;

    localparam int N = 100;
    localparam int M = 30;

    logic         clk = 1'b0;
    logic         resetn;
    logic [M-1:0] input_data;
    logic         input_valid;
    logic         input_ready;
    logic [N-1:0] output_data;
    logic         output_valid;
    logic         serial_out;
    logic         serial_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit           chk_en   = 1'b0;
    bit           m_active = 1'b0;
    int           m_j      = 0;
    logic [N-1:0] m_frame  = '0;
    logic [N-1:0] m_od     = '0;

    hadamard_pam_transmitter dut (
        .clk          (clk),
        .resetn       (resetn),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_valid (output_valid),
        .serial_out   (serial_out),
        .serial_valid (serial_valid)
    );

    always #5 clk = ~clk;

    // Frame straight from the chip formula: sum of s_k over rows with even
    // popcount(k & n), preamble on top, chip 0 most significant.
    function automatic logic [N-1:0] model_frame(input logic [M-1:0] d);
        logic [N-1:0] f;
        int s [16];
        int sum;
        f = '0;
        for (int k = 1; k < 16; k++) begin
            s[k] = int'(d[M-1-(k-1)*2 -: 2]);
`ifdef HADAMARD_TX_GRAY_MAP_EN
            s[k] = s[k] ^ (s[k] >> 1);
`endif
        end
        for (int n = 0; n < 16; n++) begin
            sum = 0;
            for (int k = 1; k < 16; k++) begin
                if (($countones(k & n) % 2) == 0) sum += s[k];
            end
            f[95-n*6 -: 6] = 6'(sum);
        end
        f[99:96] = 4'b1010;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: j counts edges since acceptance; the transmitter is ready again
    // once j reaches 116, publishes at j=16 and serializes for j=17..116.
    always @(posedge clk) begin
        bit rdy;
        cyc++;
        if (resetn) begin
            m_active = 1'b0;
            m_j      = 0;
            m_od     = '0;
        end else begin
            rdy = !m_active || (m_j >= 116);
            if (input_valid && rdy) begin
                m_active = 1'b1;
                m_j      = 0;
                m_frame  = model_frame(input_data);
            end else if (m_active) begin
                m_j++;
                if (m_j == 16) m_od = m_frame;
                if (m_j > 116) m_active = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic e_rdy, e_ov, e_sv, e_so;
        if (chk_en) begin
            e_rdy = !m_active || (m_j >= 116);
            e_ov  = m_active && (m_j == 16);
            e_sv  = m_active && (m_j >= 17) && (m_j <= 116);
            e_so  = e_sv ? m_frame[N-1-(m_j-17)] : 1'b0;
            chk("input_ready",  N'(input_ready),  N'(e_rdy));
            chk("output_valid", N'(output_valid), N'(e_ov));
            chk("serial_valid", N'(serial_valid), N'(e_sv));
            chk("serial_out",   N'(serial_out),   N'(e_so));
            chk("output_data",  output_data,      m_od);
        end
    end

    task automatic send(input logic [M-1:0] d);
        input_data  = d;
        input_valid = 1'b1;
        tick(1);
        input_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_frame;
        logic [5:0]   c0, c1, c2;
        int t0, t1, i;

        resetn      = 1'b1;
        input_valid = 1'b0;
        input_data  = '0;
        tick(1);
        chk_en = 1'b1;
        chk("rst_output_data", output_data, '0);
        chk("rst_serial_valid", N'(serial_valid), '0);
        tick(1);
        resetn = 1'b0;
        tick(1);
        chk("rst_input_ready", N'(input_ready), N'(1'b1));

        // All-zero payload: preamble followed by zeros.
        send(30'h0);
        tick(118);
        exp_frame = '0;
        exp_frame[99:96] = 4'hA;
        chk("zero_frame", output_data, exp_frame);

        // s_1 = 3 only.
        send(30'h3000_0000);
        tick(118);
        c0 = output_data[95 -: 6];
        c1 = output_data[89 -: 6];
        c2 = output_data[83 -: 6];
`ifdef HADAMARD_TX_GRAY_MAP_EN
        chk("s1_chip0", N'(c0), N'(6'd2));
        chk("s1_chip2", N'(c2), N'(6'd2));
`else
        chk("s1_chip0", N'(c0), N'(6'd3));
        chk("s1_chip2", N'(c2), N'(6'd3));
`endif
        chk("s1_chip1", N'(c1), N'(6'd0));

        // All-ones payload.
        send(30'h3FFF_FFFF);
        tick(118);
        c0 = output_data[95 -: 6];
        c1 = output_data[5 -: 6];
`ifdef HADAMARD_TX_GRAY_MAP_EN
        chk("ones_chip0", N'(c0), N'(6'd30));
        chk("ones_chip15", N'(c1), N'(6'd14));
`else
        chk("ones_chip0", N'(c0), N'(6'd45));
        chk("ones_chip15", N'(c1), N'(6'd21));
`endif

        // s_1 = 2: Gray build maps it to level 3.
        send(30'h2000_0000);
        tick(118);
        c0 = output_data[95 -: 6];
`ifdef HADAMARD_TX_GRAY_MAP_EN
        chk("gray_chip0", N'(c0), N'(6'd3));
`else
        chk("bin_chip0", N'(c0), N'(6'd2));
`endif

        // Back-to-back words with input_valid held high.
        t0 = -1;
        t1 = -1;
        input_data  = 30'h1234_5678;
        input_valid = 1'b1;
        for (i = 0; i < 300 && t1 < 0; i++) begin
            if (input_ready) begin
                if (t0 < 0) t0 = cyc;
                else        t1 = cyc;
            end
            tick(1);
            if (t0 >= 0 && t1 < 0) input_data = 30'h0ABC_DEF1;
        end
        input_valid = 1'b0;
        if (t1 < 0) chk("b2b_timeout", N'(1'b1), N'(1'b0));
        else        chk("b2b_spacing", N'(t1 - t0), N'(117));
        tick(118);

        // Reset while serial bit 50 is on the line.
        send(30'($urandom));
        for (i = 0; i < 200 && !(m_active && m_j == 67); i++) tick(1);
        if (!(m_active && m_j == 67)) chk("bit50_timeout", N'(1'b1), N'(1'b0));
        resetn = 1'b1;
        tick(1);
        resetn = 1'b0;
        chk("abort_serial_valid", N'(serial_valid), N'(1'b0));
        chk("abort_output_valid", N'(output_valid), N'(1'b0));
        chk("abort_ready", N'(input_ready), N'(1'b1));
        send(30'h0);
        tick(118);
        chk("after_abort_frame", output_data, exp_frame);

        // input_valid together with reset must not start a frame.
        resetn      = 1'b1;
        input_valid = 1'b1;
        input_data  = 30'h3FFF_FFFF;
        tick(1);
        resetn      = 1'b0;
        input_valid = 1'b0;
        tick(1);
        chk("valid_in_reset_ready", N'(input_ready), N'(1'b1));
        chk("valid_in_reset_data", output_data, '0);

        // Randomized traffic with occasional resets.
        for (i = 0; i < 2000; i++) begin
            input_valid = ($urandom_range(0, 2) == 0);
            input_data  = 30'($urandom);
            resetn      = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        resetn      = 1'b0;
        input_valid = 1'b0;
        tick(120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
